// File: rtl/operand_sequencer_pkg.sv
// Shared types and default widths for the operand sequencer.
package operand_sequencer_pkg;

   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StIssue,
      StWait,
      StDone
   } state_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// ROM, adder handshake and status bundle; master is the sequencer side.
interface operand_sequencer_if #(
   parameter int unsigned ADDR_W = operand_sequencer_pkg::DEF_ADDR_W,
   parameter int unsigned DATA_W = operand_sequencer_pkg::DEF_DATA_W
);
   logic              start;
   logic [ADDR_W:0]   num_ops;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_x;
   logic [DATA_W-1:0] rom_y;
   logic              rom_c;
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] x_out;
   logic [DATA_W-1:0] y_out;
   logic              c_out;
   logic              res_valid;
   logic [DATA_W-1:0] res_sum;
   logic              res_cout;
   logic [DATA_W-1:0] sum_q;
   logic              cout_q;
   logic              res_strobe;
   logic [ADDR_W-1:0] res_addr;
   logic [ADDR_W:0]   cout_cnt;
   logic              busy;
   logic              done;
   logic              proto_err;

   modport master (
      input  start, num_ops, rom_x, rom_y, rom_c, op_ready, res_valid, res_sum, res_cout,
      output rom_addr, op_valid, x_out, y_out, c_out, sum_q, cout_q, res_strobe, res_addr,
             cout_cnt, busy, done, proto_err
   );

   modport slave (
      output start, num_ops, rom_x, rom_y, rom_c, op_ready, res_valid, res_sum, res_cout,
      input  rom_addr, op_valid, x_out, y_out, c_out, sum_q, cout_q, res_strobe, res_addr,
             cout_cnt, busy, done, proto_err
   );

endinterface

// File: rtl/operand_sequencer.sv
// Walks the operand ROM, issues each x/y/carry triple to the adder and collects the results.
module operand_sequencer
   import operand_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input logic                clk,
   input logic                reset_n,
   operand_sequencer_if.master bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   num_q, num_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
   logic              c_q, c_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              cout_q, cout_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              strobe_q, strobe_d;
   logic              err_q, err_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         c_q      <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         raddr_q  <= '0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         num_q    <= num_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         c_q      <= c_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         raddr_q  <= raddr_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      c_d      = c_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      raddr_d  = raddr_q;
      strobe_d = 1'b0;
      err_d    = err_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               addr_d = '0;
               cnt_d  = '0;
               if (bus.num_ops == '0) begin
                  state_d = StDone;
               end else begin
                  err_d   = 1'b0;
                  num_d   = bus.num_ops;
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            x_d     = bus.rom_x;
            y_d     = bus.rom_y;
            c_d     = bus.rom_c;
            state_d = StIssue;
         end
         StIssue: begin
            if (bus.op_ready) state_d = StWait;
         end
         StWait: begin
            if (bus.res_valid) begin
               sum_d    = bus.res_sum;
               cout_d   = bus.res_cout;
               raddr_d  = addr_q;
               strobe_d = 1'b1;
               cnt_d    = cnt_q + {{ADDR_W{1'b0}}, bus.res_cout};
               // Widened compare so num_ops == 2**ADDR_W stops at the top entry without wrapping.
               if ({1'b0, addr_q} == num_q - (ADDR_W + 1)'(1)) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (bus.res_valid && (state_q != StWait)) err_d = 1'b1;
   end

   assign bus.rom_addr   = addr_q;
   assign bus.op_valid   = (state_q == StIssue);
   assign bus.x_out      = x_q;
   assign bus.y_out      = y_q;
   assign bus.c_out      = c_q;
   assign bus.sum_q      = sum_q;
   assign bus.cout_q     = cout_q;
   assign bus.res_strobe = strobe_q;
   assign bus.res_addr   = raddr_q;
   assign bus.cout_cnt   = cnt_q;
   assign bus.busy       = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
   assign bus.done       = (state_q == StDone);
   assign bus.proto_err  = err_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench: expected results queued at stimulus time, popped on each res_strobe.
module tb_operand_sequencer;
   import operand_sequencer_pkg::*;

   localparam int unsigned AW = DEF_ADDR_W;
   localparam int unsigned DW = DEF_DATA_W;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] sum;
      logic          cout;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   operand_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   operand_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] rx [32];
   logic [DW-1:0] ry [32];
   logic          rc [32];

   assign bus.rom_x = rx[bus.rom_addr];
   assign bus.rom_y = ry[bus.rom_addr];
   assign bus.rom_c = rc[bus.rom_addr];

   logic          adder_en = 1'b1;
   logic          pend = 1'b0, pend_cout = 1'b0;
   logic [DW-1:0] pend_sum = '0;
   logic          mdl_rv = 1'b0, mdl_cout = 1'b0;
   logic [DW-1:0] mdl_sum = '0;
   logic          inj_rv = 1'b0, inj_cout = 1'b0;
   logic [DW-1:0] inj_sum = '0;

   assign bus.res_valid = mdl_rv | inj_rv;
   assign bus.res_sum   = inj_rv ? inj_sum : mdl_sum;
   assign bus.res_cout  = inj_rv ? inj_cout : mdl_cout;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic ov_seen = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // One-cycle-latency adder: result presented the cycle after the handshake.
   initial forever begin
      @(negedge clk);
      mdl_rv   = pend;
      mdl_sum  = pend_sum;
      mdl_cout = pend_cout;
      pend     = adder_en && bus.op_valid && bus.op_ready;
      {pend_cout, pend_sum} = {1'b0, bus.x_out} + {1'b0, bus.y_out} + {{DW{1'b0}}, bus.c_out};
   end

   initial forever begin
      @(negedge clk);
      if (bus.op_valid) ov_seen = 1'b1;
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && bus.res_strobe) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL strobe_unexpected: got strobe at res_addr=%0d, required none",
                        bus.res_addr);
            end else begin
               e = q.pop_front();
               chk("res_sum", 64'(bus.sum_q), 64'(e.sum));
               chk("res_cout", 64'(bus.cout_q), 64'(e.cout));
               chk("res_addr", 64'(bus.res_addr), 64'(e.addr));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 0);
      chk({tag, "_x_out"}, 64'(bus.x_out), 0);
      chk({tag, "_y_out"}, 64'(bus.y_out), 0);
      chk({tag, "_c_out"}, 64'(bus.c_out), 0);
      chk({tag, "_sum_q"}, 64'(bus.sum_q), 0);
      chk({tag, "_cout_q"}, 64'(bus.cout_q), 0);
      chk({tag, "_res_addr"}, 64'(bus.res_addr), 0);
      chk({tag, "_cout_cnt"}, 64'(bus.cout_cnt), 0);
      chk({tag, "_proto_err"}, 64'(bus.proto_err), 0);
      chk({tag, "_op_valid"}, 64'(bus.op_valid), 0);
      chk({tag, "_res_strobe"}, 64'(bus.res_strobe), 0);
      chk({tag, "_busy"}, 64'(bus.busy), 0);
      chk({tag, "_done"}, 64'(bus.done), 0);
   endtask

   task automatic start_run(input int n);
      tick();
      bus.start   = 1'b1;
      bus.num_ops = (AW + 1)'(n);
      tick();
      bus.start   = 1'b0;
   endtask

   // Counts cycles after the start edge; optionally pulses start again mid-run.
   task automatic wait_done(input int budget, input int poke_at, output int cyc);
      cyc = 0;
      while (!bus.done && cyc < budget) begin
         tick();
         cyc++;
         bus.start = (cyc == poke_at);
         if (cyc == poke_at) bus.num_ops = 6'd5;
      end
      bus.start = 1'b0;
      chk("done_reached", 64'(bus.done), 1);
   endtask

   task automatic inject(input logic [DW-1:0] s, input logic co);
      tick();
      inj_sum  = s;
      inj_cout = co;
      inj_rv   = 1'b1;
      tick();
      inj_rv   = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish by 200000ns, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int cyc;
      int n;
      bus.start    = 1'b0;
      bus.num_ops  = '0;
      bus.op_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rx[i] = '0;
         ry[i] = '0;
         rc[i] = 1'b0;
      end

      repeat (3) tick();
      check_zero("rst");
      reset_n = 1'b1;

      // Three-entry run: 1+2+0, FFFFFFFF+1+0, 7+8+1.
      rx[0] = 32'd1;          ry[0] = 32'd2; rc[0] = 1'b0;
      rx[1] = 32'hFFFF_FFFF;  ry[1] = 32'd1; rc[1] = 1'b0;
      rx[2] = 32'd7;          ry[2] = 32'd8; rc[2] = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         q.push_back('{addr: 5'd0, sum: 32'd3,  cout: 1'b0});
         q.push_back('{addr: 5'd1, sum: 32'd0,  cout: 1'b1});
         q.push_back('{addr: 5'd2, sum: 32'd16, cout: 1'b0});
         start_run(3);
         chk("t3_busy", 64'(bus.busy), 1);
         wait_done(200, (pass == 1) ? 4 : 0, cyc);
         chk("t3_cycles", 64'(cyc), 9);
         chk("t3_cout_cnt", 64'(bus.cout_cnt), 1);
         chk("t3_rom_addr", 64'(bus.rom_addr), 2);
         chk("t3_busy_end", 64'(bus.busy), 0);
         repeat (3) tick();
         chk("t3_done_hold", 64'(bus.done), 1);
         chk("t3_queue_empty", 64'(q.size()), 0);
      end

      // num_ops = 0 goes straight to DONE and clears the counters.
      ov_seen = 1'b0;
      start_run(0);
      chk("z_done", 64'(bus.done), 1);
      chk("z_busy", 64'(bus.busy), 0);
      chk("z_cout_cnt", 64'(bus.cout_cnt), 0);
      chk("z_rom_addr", 64'(bus.rom_addr), 0);
      repeat (3) tick();
      chk("z_no_op_valid", 64'(ov_seen), 0);

      // Backpressure: operands must stay put while op_ready is low.
      rx[0] = 32'd7; ry[0] = 32'd8; rc[0] = 1'b1;
      bus.op_ready = 1'b0;
      q.push_back('{addr: 5'd0, sum: 32'd16, cout: 1'b0});
      start_run(1);
      n = 0;
      while (!bus.op_valid && n < 20) begin
         tick();
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("st_op_valid", 64'(bus.op_valid), 1);
         chk("st_x_out", 64'(bus.x_out), 7);
         chk("st_y_out", 64'(bus.y_out), 8);
         chk("st_c_out", 64'(bus.c_out), 1);
         tick();
      end
      bus.op_ready = 1'b1;
      wait_done(50, 0, cyc);
      repeat (3) tick();
      chk("st_queue_empty", 64'(q.size()), 0);
      chk("st_cout_cnt", 64'(bus.cout_cnt), 0);

      // Full ROM, every entry carries out.
      for (int i = 0; i < 32; i++) begin
         rx[i] = 32'hFFFF_FFFF;
         ry[i] = 32'hFFFF_FFFF;
         rc[i] = 1'b1;
         q.push_back('{addr: AW'(i), sum: 32'hFFFF_FFFF, cout: 1'b1});
      end
      start_run(32);
      wait_done(400, 0, cyc);
      chk("f_cycles", 64'(cyc), 96);
      chk("f_cout_cnt", 64'(bus.cout_cnt), 32);
      chk("f_rom_addr", 64'(bus.rom_addr), 31);
      repeat (3) tick();
      chk("f_res_addr", 64'(bus.res_addr), 31);
      chk("f_queue_empty", 64'(q.size()), 0);

      // Stray result in DONE: flagged, data discarded.
      inject(32'h1234, 1'b0);
      chk("dn_proto_err", 64'(bus.proto_err), 1);
      chk("dn_sum_q", 64'(bus.sum_q), 64'h0000_0000_FFFF_FFFF);
      chk("dn_cout_q", 64'(bus.cout_q), 1);
      chk("dn_done", 64'(bus.done), 1);

      // Abort in WAIT with a silent adder, then a late result in IDLE.
      adder_en = 1'b0;
      start_run(2);
      chk("ab_err_cleared", 64'(bus.proto_err), 0);
      n = 0;
      while (!bus.op_valid && n < 20) begin
         tick();
         n++;
      end
      tick();
      chk("ab_in_wait_busy", 64'(bus.busy), 1);
      chk("ab_in_wait_ov", 64'(bus.op_valid), 0);
      reset_n = 1'b0;
      tick();
      check_zero("abort");
      reset_n = 1'b1;
      tick();
      chk("ab_idle_busy", 64'(bus.busy), 0);
      chk("ab_idle_done", 64'(bus.done), 0);
      inject(32'hABCD, 1'b1);
      chk("ab_proto_err", 64'(bus.proto_err), 1);
      chk("ab_sum_q", 64'(bus.sum_q), 0);
      chk("ab_cout_cnt", 64'(bus.cout_cnt), 0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
